// File: rtl/gshare_pattern_table_if.sv
// -----------------------------------------------------------------------------
// gshare_pattern_table_if
//
// Bundles the fetch-side prediction port and the resolve-side update port of
// the gshare pattern table so the predictor and its neighbours share one
// connection.
//
// Signals
//   ready         predictor -> fetch    table initialised, requests accepted
//   pred_req      fetch -> predictor    prediction request
//   pred_pc       fetch -> predictor    16-bit PC of the fetched instruction
//   pred_valid    predictor -> fetch    prediction outputs valid this cycle
//   pred_taken    predictor -> fetch    predicted direction
//   pred_index    predictor -> fetch    table index used, returned on update
//   update_valid  resolve -> predictor  resolved branch
//   update_index  resolve -> predictor  index from the original prediction
//   update_taken  resolve -> predictor  actual branch direction
//   ghr           predictor -> fetch    current global history
//
// Modports
//   master : the pipeline side (drives requests, observes results)
//   slave  : the predictor
// -----------------------------------------------------------------------------
interface gshare_pattern_table_if #(
    parameter int INDEX_BITS = 12,
    parameter int HIST_BITS  = 12
);
    logic                  ready;
    logic                  pred_req;
    logic [15:0]           pred_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] update_index;
    logic                  update_taken;
    logic [HIST_BITS-1:0]  ghr;

    modport master (
        input  ready,
        input  pred_valid,
        input  pred_taken,
        input  pred_index,
        input  ghr,
        output pred_req,
        output pred_pc,
        output update_valid,
        output update_index,
        output update_taken
    );

    modport slave (
        output ready,
        output pred_valid,
        output pred_taken,
        output pred_index,
        output ghr,
        input  pred_req,
        input  pred_pc,
        input  update_valid,
        input  update_index,
        input  update_taken
    );
endinterface

// File: rtl/gshare_pattern_table.sv
// -----------------------------------------------------------------------------
// gshare_pattern_table
//
// gshare branch-direction predictor. A table of 2^INDEX_BITS saturating
// counters is indexed by PC[INDEX_BITS:1] XOR the zero-extended global history.
// After reset the block sweeps the whole table to weakly-not-taken (ready=0),
// then accepts one prediction and one update per cycle.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    gshare_pattern_table_if.slave (prediction + update ports, ghr)
//
// Parameters
//   INDEX_BITS  log2 of table depth
//   HIST_BITS   global history length, 1..INDEX_BITS
//   CTR_BITS    counter width, >= 2
//
// Optional feature macro: GSHARE_PRED_BYPASS_EN
//   defined   : a prediction whose index matches the in-flight update (U1)
//               sees the counter value being written at that same edge.
//   undefined : predictions read the stored array value only.
// -----------------------------------------------------------------------------
module gshare_pattern_table #(
    parameter int INDEX_BITS = 12,
    parameter int HIST_BITS  = 12,
    parameter int CTR_BITS   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    gshare_pattern_table_if.slave  bus
);

    localparam int DEPTH = 1 << INDEX_BITS;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CTR_BITS-1:0]   CTR_ZERO = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]   CTR_ONE  = CTR_BITS'(1'b1);
    localparam logic [CTR_BITS-1:0]   WEAK_NT  = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [INDEX_BITS-1:0] IDX_ONE  = INDEX_BITS'(1'b1);
    localparam logic [INDEX_BITS-1:0] IDX_LAST = {INDEX_BITS{1'b1}};

    // Reject configurations the hashing and counter logic cannot support.
    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS || CTR_BITS < 2 || INDEX_BITS > 15) begin : g_param_check
        $error("gshare_pattern_table: unsupported INDEX_BITS/HIST_BITS/CTR_BITS");
    end

    // Saturating counter step: taken counts up to all-ones, not-taken down to 0.
    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                    input logic                taken);
        logic [CTR_BITS-1:0] nxt;
        if (taken) begin
            if (ctr == CTR_MAX) begin
                nxt = CTR_MAX;
            end else begin
                nxt = ctr + CTR_ONE;
            end
        end else begin
            if (ctr == CTR_ZERO) begin
                nxt = CTR_ZERO;
            end else begin
                nxt = ctr - CTR_ONE;
            end
        end
        return nxt;
    endfunction

    // Counter storage; no reset, the INIT sweep establishes its contents.
    logic [CTR_BITS-1:0] pht_mem [DEPTH];

    // Control / pipeline state
    logic [0:0]            state_q,      state_d;
    logic [INDEX_BITS-1:0] init_cnt_q,   init_cnt_d;
    logic                  ready_q,      ready_d;
    logic                  u1_valid_q,   u1_valid_d;
    logic [INDEX_BITS-1:0] u1_index_q,   u1_index_d;
    logic                  u1_taken_q,   u1_taken_d;
    logic [HIST_BITS-1:0]  ghr_q,        ghr_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;

    // Combinational helpers
    logic                  run_s;
    logic [HIST_BITS:0]    ghr_shift_s;
    logic [INDEX_BITS-1:0] pred_idx_s;
    logic [CTR_BITS-1:0]   u1_next_s;
    logic                  pred_msb_s;
    logic                  wr_en_s;
    logic [INDEX_BITS-1:0] wr_idx_s;
    logic [CTR_BITS-1:0]   wr_data_s;
    logic                  unused_s;

    assign run_s = (state_q == ST_RUN);

    // Only PC[INDEX_BITS:1] feeds the hash, and the bit shifted out of the
    // history register is discarded; fold the leftovers into a sink.
    assign unused_s = ^{bus.pred_pc, ghr_shift_s[HIST_BITS]};

    // Hash, U1 read-modify value and prediction counter MSB.
    always_comb begin
        ghr_shift_s = {ghr_q, bus.update_taken};
        pred_idx_s  = bus.pred_pc[INDEX_BITS:1] ^ INDEX_BITS'(ghr_q);
        // The U1 read sees any write from the previous update because that
        // write lands at the edge that loaded U1, so no forwarding is needed.
        u1_next_s   = ctr_next(pht_mem[u1_index_q], u1_taken_q);
`ifdef GSHARE_PRED_BYPASS_EN
        if (u1_valid_q && (u1_index_q == pred_idx_s)) begin
            pred_msb_s = u1_next_s[CTR_BITS-1];
        end else begin
            pred_msb_s = pht_mem[pred_idx_s][CTR_BITS-1];
        end
`else
        pred_msb_s = pht_mem[pred_idx_s][CTR_BITS-1];
`endif
    end

    // INIT sweep sequencing and ready generation.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + IDX_ONE;
                if (init_cnt_q == IDX_LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_INIT;
                    ready_d = 1'b0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = {INDEX_BITS{1'b0}};
                ready_d    = 1'b0;
            end
        endcase
    end

    // Update capture into U1 and global history shift.
    always_comb begin
        u1_valid_d = 1'b0;
        u1_index_d = u1_index_q;
        u1_taken_d = u1_taken_q;
        ghr_d      = ghr_q;
        if (run_s && bus.update_valid) begin
            u1_valid_d = 1'b1;
            u1_index_d = bus.update_index;
            u1_taken_d = bus.update_taken;
            ghr_d      = ghr_shift_s[HIST_BITS-1:0];
        end else begin
            u1_valid_d = 1'b0;
        end
    end

    // Prediction register: outputs hold when no request is accepted.
    always_comb begin
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (run_s && bus.pred_req) begin
            pred_valid_d = 1'b1;
            pred_taken_d = pred_msb_s;
            pred_index_d = pred_idx_s;
        end else begin
            pred_valid_d = 1'b0;
        end
    end

    // Table write port: INIT sweep, or the U1 saturated result in RUN.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = u1_index_q;
        wr_data_s = u1_next_s;
        case (state_q)
            ST_INIT: begin
                wr_en_s   = 1'b1;
                wr_idx_s  = init_cnt_q;
                wr_data_s = WEAK_NT;
            end
            ST_RUN: begin
                wr_en_s   = u1_valid_q;
                wr_idx_s  = u1_index_q;
                wr_data_s = u1_next_s;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Counter array write.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            pht_mem[wr_idx_s] <= wr_data_s;
        end
    end

    // State and output registers; reset drops any pending U1 write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= {INDEX_BITS{1'b0}};
            ready_q      <= 1'b0;
            u1_valid_q   <= 1'b0;
            u1_index_q   <= {INDEX_BITS{1'b0}};
            u1_taken_q   <= 1'b0;
            ghr_q        <= {HIST_BITS{1'b0}};
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= {INDEX_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            ready_q      <= ready_d;
            u1_valid_q   <= u1_valid_d;
            u1_index_q   <= u1_index_d;
            u1_taken_q   <= u1_taken_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_index = pred_index_q;
    assign bus.ghr        = ghr_q;

endmodule

// File: tb/tb_gshare_pattern_table.sv
// -----------------------------------------------------------------------------
// tb_gshare_pattern_table
//
// Directed and randomized checks of gshare_pattern_table against a reference
// model: an integer counter array, an integer history value and a queue of
// pending updates that land one edge after capture.
// -----------------------------------------------------------------------------
module tb_gshare_pattern_table;

    localparam int IB      = 12;
    localparam int HB      = 12;
    localparam int CB      = 2;
    localparam int DEPTH   = 1 << IB;
    localparam int IMASK   = DEPTH - 1;
    localparam int HMASK   = (1 << HB) - 1;
    localparam int CMAX    = (1 << CB) - 1;
    localparam int WEAK_NT = (1 << (CB - 1)) - 1;
    localparam int MSB_T   = 1 << (CB - 1);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    gshare_pattern_table_if #(.INDEX_BITS(IB), .HIST_BITS(HB)) bus ();

    gshare_pattern_table #(
        .INDEX_BITS(IB),
        .HIST_BITS (HB),
        .CTR_BITS  (CB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int idx;
        bit tk;
    } upd_t;

    int   m_ctr [DEPTH];
    int   m_ghr;
    bit   m_ready;
    int   m_init_cnt;
    int   m_edge = 0;
    bit   m_pvalid;
    bit   m_ptaken;
    int   m_pindex;
    upd_t m_pend[$];

    function automatic int sat(input int v, input bit t);
        if (t) return (v >= CMAX) ? CMAX : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = WEAK_NT;
        m_ghr      = 0;
        m_ready    = 1'b0;
        m_init_cnt = 0;
        m_pvalid   = 1'b0;
        m_ptaken   = 1'b0;
        m_pindex   = 0;
        m_pend.delete();
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input bit preq, input logic [15:0] pc, input bit uv,
                              input logic [IB-1:0] ui, input bit ut);
        int   idx;
        int   v;
        upd_t u;
        m_edge++;
        m_pvalid = 1'b0;
        if (!m_ready) begin
            m_init_cnt++;
            if (m_init_cnt == DEPTH) m_ready = 1'b1;
            return;
        end
        if (preq) begin
            idx = ((int'(pc) >> 1) & IMASK) ^ m_ghr;
            v   = m_ctr[idx];
`ifdef GSHARE_PRED_BYPASS_EN
            if (m_pend.size() > 0 && m_pend[0].due == m_edge && m_pend[0].idx == idx)
                v = sat(v, m_pend[0].tk);
`endif
            m_pvalid = 1'b1;
            m_ptaken = (v >= MSB_T);
            m_pindex = idx;
        end
        while (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
            u = m_pend.pop_front();
            m_ctr[u.idx] = sat(m_ctr[u.idx], u.tk);
        end
        if (uv) begin
            m_pend.push_back('{m_edge + 1, int'(ui), ut});
            m_ghr = ((m_ghr << 1) | int'(ut)) & HMASK;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("ready",      int'(bus.ready),      int'(m_ready));
        chk("pred_valid", int'(bus.pred_valid), int'(m_pvalid));
        chk("pred_taken", int'(bus.pred_taken), int'(m_ptaken));
        chk("pred_index", int'(bus.pred_index), m_pindex);
        chk("ghr",        int'(bus.ghr),        m_ghr);
    endtask

    // One clock: drive at posedge+1, model the edge, sample at next posedge+1.
    task automatic cycle(input bit preq, input logic [15:0] pc, input bit uv,
                         input logic [IB-1:0] ui, input bit ut);
        bus.pred_req     = preq;
        bus.pred_pc      = pc;
        bus.update_valid = uv;
        bus.update_index = ui;
        bus.update_taken = ut;
        model_step(preq, pc, uv, ui, ut);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_cycle();
        cycle(1'($urandom), 16'($urandom), 1'($urandom), IB'($urandom), 1'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 16'($urandom), 1'b0, IB'($urandom), 1'($urandom));
    endtask

    task automatic upd(input logic [IB-1:0] idx, input bit t);
        cycle(1'b0, 16'($urandom), 1'b1, idx, t);
    endtask

    task automatic pred(input logic [15:0] pc);
        cycle(1'b1, pc, 1'b0, IB'($urandom), 1'($urandom));
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release one edge later.
    task automatic apply_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst_ready",      int'(bus.ready),      0);
        chk("rst_pred_valid", int'(bus.pred_valid), 0);
        chk("rst_pred_taken", int'(bus.pred_taken), 0);
        chk("rst_pred_index", int'(bus.pred_index), 0);
        chk("rst_ghr",        int'(bus.ghr),        0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Full INIT sweep with random (ignored) traffic and exact ready timing.
    task automatic run_init(input bit traffic);
        for (int i = 1; i <= DEPTH; i++) begin
            if (traffic) rand_cycle();
            else idle(1);
            if (i == DEPTH - 1) chk("ready_low_before_end", int'(bus.ready), 0);
            if (i == DEPTH)     chk("ready_high_at_end",    int'(bus.ready), 1);
        end
    endtask

    task automatic clear_ghr();
        for (int i = 0; i < 12; i++) upd(12'h100, 1'b0);
        chk("ghr_cleared", int'(bus.ghr), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] hist_seq;
        bit          preq;
        bit          uv;
        bit          ut;
        logic [IB-1:0] tgt;
        logic [IB-1:0] ui;
        logic [15:0] pc;

        bus.pred_req     = 1'b0;
        bus.pred_pc      = 16'h0000;
        bus.update_valid = 1'b0;
        bus.update_index = {IB{1'b0}};
        bus.update_taken = 1'b0;
        model_reset();
        #1;
        apply_reset();

        // Reset again partway through INIT; the sweep must restart from zero.
        for (int i = 0; i < 100; i++) rand_cycle();
        apply_reset();
        run_init(1'b1);

        // First prediction after init: weak not-taken, index is PC[12:1].
        pred(16'h1234);
        chk("first_pred_valid", int'(bus.pred_valid), 1);
        chk("first_pred_index", int'(bus.pred_index), 'h91A);
        chk("first_pred_taken", int'(bus.pred_taken), 0);

        // Saturation up and down at index 0x005.
        clear_ghr();
        for (int i = 0; i < 3; i++) upd(12'h005, 1'b1);
        clear_ghr();
        pred(16'h000A);
        chk("sat_up_index", int'(bus.pred_index), 'h005);
        chk("sat_up_taken", int'(bus.pred_taken), 1);
        for (int i = 0; i < 4; i++) upd(12'h005, 1'b0);
        idle(2);
        pred(16'h000A);
        chk("sat_down_index", int'(bus.pred_index), 'h005);
        chk("sat_down_taken", int'(bus.pred_taken), 0);

        // History shift order and PC hashing.
        hist_seq = 12'h0F3;
        for (int i = 11; i >= 0; i--) begin
            upd(12'h300, hist_seq[i]);
            if (i == 6) chk("ghr_half", int'(bus.ghr), 'h003);
        end
        chk("ghr_0f3", int'(bus.ghr), 'h0F3);
        pred(16'h1234);
        chk("hash_index", int'(bus.pred_index), 'h9E9);

        // Prediction colliding with the in-flight update at index 0x010.
        clear_ghr();
        upd(12'h010, 1'b1);
        pred(16'h0022);
        chk("collide_index", int'(bus.pred_index), 'h010);
`ifdef GSHARE_PRED_BYPASS_EN
        chk("collide_taken", int'(bus.pred_taken), 1);
`else
        chk("collide_taken", int'(bus.pred_taken), 0);
`endif
        idle(1);
        pred(16'h0022);
        chk("collide_after_taken", int'(bus.pred_taken), 1);

        // Back-to-back updates to 0x020: 01 -> 10 -> 11, then one down to 10.
        upd(12'h020, 1'b1);
        upd(12'h020, 1'b1);
        upd(12'h020, 1'b0);
        chk("b2b_ghr", int'(bus.ghr), 'h00E);
        idle(2);
        pred(16'h005C);
        chk("b2b_index", int'(bus.pred_index), 'h020);
        chk("b2b_taken", int'(bus.pred_taken), 1);

        // Randomized concurrent traffic biased toward a few hot indices.
        for (int i = 0; i < 3000; i++) begin
            preq = ($urandom_range(0, 3) != 0);
            uv   = ($urandom_range(0, 1) != 0);
            ut   = 1'($urandom);
            if ($urandom_range(0, 1) != 0) ui = IB'($urandom_range(0, 15));
            else ui = IB'($urandom);
            if ($urandom_range(0, 1) != 0) tgt = IB'($urandom_range(0, 15));
            else tgt = IB'($urandom);
            pc = {3'($urandom), tgt ^ IB'(m_ghr), 1'($urandom)};
            cycle(preq, pc, uv, ui, ut);
        end

        // Reset with U1 occupied: the taken update to 0x040 must be lost.
        upd(12'h040, 1'b1);
        apply_reset();
        run_init(1'b0);
        pred(16'h0080);
        chk("post_reset_index", int'(bus.pred_index), 'h040);
        chk("post_reset_taken", int'(bus.pred_taken), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gshare_pattern_table.md
# gshare_pattern_table

Parametrised gshare branch-direction predictor: a table of saturating counters indexed by PC XOR global history, with a registered prediction port for fetch and a pipelined read-modify-write update port for branch resolution. It replaces the fixed 4096-entry, externally-managed pattern array. Counters, history register and table initialisation now live inside the block. Sits beside the fetch stage; the prediction index is carried down the pipeline and returned on update.

## Interface
Parameters:
- INDEX_BITS, 12, log2 of table depth (2^INDEX_BITS entries)
- HIST_BITS, 12, global history length; must satisfy 1 <= HIST_BITS <= INDEX_BITS
- CTR_BITS, 2, counter width; must be >= 2

Ports:
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high
- ready  out  1  table initialised, requests accepted
- pred_req  in  1  prediction request
- pred_pc  in  16  lc3b_word PC of the fetched instruction
- pred_valid  out  1  prediction outputs valid this cycle
- pred_taken  out  1  predicted direction (counter MSB)
- pred_index  out  INDEX_BITS  table index used, returned later on update
- update_valid  in  1  resolved branch
- update_index  in  INDEX_BITS  index from the original prediction
- update_taken  in  1  actual direction
- ghr  out  HIST_BITS  current global history (debug/checkpoint)

## Operation
- Index = pred_pc[INDEX_BITS:1] XOR zero-extended ghr. Bit 0 of the PC is dropped.
- Counters saturate: taken increments to 2^CTR_BITS-1, not-taken decrements to 0. Prediction = counter MSB.
- WEAK_NT = 2^(CTR_BITS-1)-1 (01 for 2-bit). It is the initial value of every entry.
- States:
  - INIT: a counter sweeps indices 0..2^INDEX_BITS-1, writing WEAK_NT to one entry per cycle. ready=0. pred_req and update_valid are ignored, with no state change. After the last entry is written the block moves to RUN.
  - RUN: ready=1.
- Update pipeline:
  - At an edge with update_valid, the request is captured into stage U1 (u1_valid, u1_index, u1_taken). At the same edge, ghr <= {ghr[HIST_BITS-2:0], update_taken}.
  - During the U1 cycle, the counter at u1_index is read and its saturated next value is written at the following edge.
  - Back-to-back updates, same index or not, are processed at one per cycle. The second read sees the first write, so there is no lost update.
- Prediction: at an edge with pred_req in RUN, the index is computed from the pre-edge ghr and the table read. The counter MSB and the index are registered to pred_taken and pred_index, and pred_valid=1 for one cycle. With no pred_req, pred_valid=0 and the other outputs hold.
- Simultaneous pred_req and update_valid: the prediction uses the old ghr. The table write from U1 is governed by Configuration.

## Timing
- Reset values: ready=0, pred_valid=0, pred_taken=0, pred_index=0, ghr=0, u1_valid=0, state=INIT, init counter=0.
- Init duration: ready rises exactly 2^INDEX_BITS cycles after reset deassertion (4096 with defaults).
- Prediction latency: 1 cycle, pred_req at edge N gives outputs valid after edge N.
- Update latency: 2 edges from update_valid to counter write. ghr changes 1 edge after update_valid.
- Throughput: one prediction and one update per cycle, concurrently.
- Reset asserted at any time, including mid-INIT or with U1 occupied:
  - all outputs return to reset values immediately;
  - the pending U1 write is discarded;
  - INIT restarts from index 0.
- update_index/update_taken are don't-care when update_valid=0. pred_pc is don't-care when pred_req=0.

## Configuration
- GSHARE_PRED_BYPASS_EN defined: if u1_valid and u1_index equals the prediction index in the same cycle, the prediction uses the U1 next counter value, i.e. the value being written at that edge.
- Undefined: the prediction uses the stored array value, one update stale. No comparator is present.

## Test plan
- Reset then idle:
  - ready=0 for 4096 cycles, then 1;
  - first prediction for any PC -> pred_taken=0, pred_index=PC[12:1].
- Saturation, ghr forced 0 by 12 not-taken updates to another index:
  - 3 taken updates to index 0x005 -> counter 11, next prediction for PC 0x000A taken;
  - 4 not-taken -> counter 00, prediction not-taken, no wrap.
- Hashing:
  - after updates leaving ghr=0x0F3, pred_pc=0x1234 -> pred_index = 0x91A ^ 0x0F3 = 0x9E9;
  - ghr shift order checked against update_taken sequence.
- Bypass collision:
  - index 0x010 at WEAK_NT, taken update at cycle N, pred_req for the same index at cycle N+1;
  - with macro -> pred_taken=1; without macro -> pred_taken=0.
- Back-to-back updates: two taken updates to 0x020 on consecutive cycles from 01 -> counter 11, not 10.
- Reset mid-INIT at cycle 100 and with U1 occupied:
  - ready stays 0 for a full 4096 cycles after deassertion;
  - no write from the discarded U1 request is observed.
